// File: rtl/ib_square_8_if.sv
// Operand/result bundle for the 8-bit squarer.
// master drives the operand, slave returns the square.
interface ib_square_8_if;
  logic [7:0]  i_a;
  logic [15:0] o_c;

  modport master (
    output i_a,
    input  o_c
  );

  modport slave (
    input  i_a,
    output o_c
  );
endinterface

// File: rtl/ib_square_8.sv
// Registered 8-bit unsigned squarer built from a folded
// partial-product array, a carry-save tree and a ripple adder.
module ib_square_8 (
  input  logic         i_clk,
  input  logic         i_nrst,
  ib_square_8_if.slave bus
);

  function automatic logic [15:0] xor3(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] z
  );
    return x ^ y ^ z;
  endfunction

  // Majority shifted into its carry weight; bit 15 falls off,
  // which is safe because the true square fits in 16 bits.
  function automatic logic [15:0] maj3(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] z
  );
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [7:0]  a;
  logic [15:0] pp [8];

  assign a = bus.i_a;

  // Row 0 holds a[i] at 2i; row i+1 holds a[i]&a[j] at i+j+1.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      pp[r] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      pp[0][2*i] = a[i];
    end
    for (int i = 0; i < 7; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        pp[i+1][i+j+1] = a[i] & a[j];
      end
    end
  end

  logic [15:0] s1a, c1a, s1b, c1b;
  logic [15:0] s2a, c2a, s2b, c2b;
  logic [15:0] s3, c3;
  logic [15:0] s4, c4;

  assign s1a = xor3(pp[0], pp[1], pp[2]);
  assign c1a = maj3(pp[0], pp[1], pp[2]);
  assign s1b = xor3(pp[3], pp[4], pp[5]);
  assign c1b = maj3(pp[3], pp[4], pp[5]);

  assign s2a = xor3(s1a, c1a, s1b);
  assign c2a = maj3(s1a, c1a, s1b);
  assign s2b = xor3(c1b, pp[6], pp[7]);
  assign c2b = maj3(c1b, pp[6], pp[7]);

  assign s3 = xor3(s2a, c2a, s2b);
  assign c3 = maj3(s2a, c2a, s2b);

  assign s4 = xor3(s3, c3, c2b);
  assign c4 = maj3(s3, c3, c2b);

  logic [15:0] cy;
  logic [15:0] sq;

  assign cy[0] = 1'b0;

  for (genvar k = 0; k < 16; k++) begin : g_rca
    assign sq[k] = s4[k] ^ c4[k] ^ cy[k];
    if (k < 15) begin : g_cy
      assign cy[k+1] = (s4[k] & c4[k])
                     | (s4[k] & cy[k])
                     | (c4[k] & cy[k]);
    end
  end

  logic [15:0] c_q;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      c_q <= '0;
    end else begin
      c_q <= sq;
    end
  end

  assign bus.o_c = c_q;

endmodule

// File: tb/tb_ib_square_8.sv
// Self-checking bench for ib_square_8: vector table,
// exhaustive sweep with mid-stream reset, hold and random runs.
module tb_ib_square_8;

  logic i_clk;
  logic i_nrst;

  ib_square_8_if bus ();

  ib_square_8 dut (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] c;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [15:0] ref_sq(input logic [7:0] v);
    int x;
    x = int'(v);
    return 16'(x * x);
  endfunction

  task automatic chk(input string nm, input logic [15:0] exp);
    n_vec++;
    if (bus.o_c !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, bus.o_c, exp);
    end
  endtask

  task automatic chk_b1(input string nm);
    n_vec++;
    if (bus.o_c[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: bit1 got %b expected 0", nm, bus.o_c[1]);
    end
  endtask

  // Drive at a falling edge, check at the next falling edge.
  task automatic step(input logic [7:0] v, input string nm);
    bus.i_a = v;
    @(negedge i_clk);
    chk(nm, ref_sq(v));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;

    tbl[0] = '{8'd0,   16'd0};
    tbl[1] = '{8'd1,   16'd1};
    tbl[2] = '{8'd2,   16'd4};
    tbl[3] = '{8'd255, 16'd65025};
    tbl[4] = '{8'd16,  16'd256};
    tbl[5] = '{8'd128, 16'd16384};
    tbl[6] = '{8'd15,  16'd225};
    tbl[7] = '{8'd127, 16'd16129};

    i_nrst = 1'b0;
    bus.i_a = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("rst_hold", 16'h0000);
    end
    i_nrst = 1'b1;
    @(negedge i_clk);
    chk("rst_release", 16'hFE01);

    for (int i = 0; i < 8; i++) begin
      bus.i_a = tbl[i].a;
      @(negedge i_clk);
      chk("table", tbl[i].c);
      chk_b1("table_bit1");
    end

    for (int v = 0; v < 256; v++) begin
      if (v == 200) begin
        bus.i_a = 8'd200;
        @(posedge i_clk);
        #2;
        i_nrst = 1'b0;
        #1;
        chk("async_clr", 16'h0000);
        @(negedge i_clk);
        chk("mid_rst_hold", 16'h0000);
        @(negedge i_clk);
        chk("mid_rst_hold2", 16'h0000);
        i_nrst = 1'b1;
        @(negedge i_clk);
        chk("mid_rst_release", 16'd40000);
      end else begin
        step(8'(v), "sweep");
      end
    end

    bus.i_a = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk);
      #1;
      chk("hold_post", 16'd9801);
      @(negedge i_clk);
      chk("hold_neg", 16'd9801);
    end

    for (int i = 0; i < 300; i++) begin
      step(8'($urandom_range(0, 255)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
